// File: rtl/mmcm_drp_reconfig.sv
// rtl/mmcm_drp_reconfig.sv - DRP read-modify-write controller retuning one MMCME2_ADV output divider
module mmcm_drp_reconfig #(
    parameter int DRP_TIMEOUT  = 255,
    parameter int LOCK_TIMEOUT = 65535
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cfg_en,
    input  logic [2:0]  cfg_sel,
    input  logic [6:0]  cfg_divide,
    output logic        cfg_busy,
    output logic        cfg_done,
    output logic        cfg_err,
    output logic [1:0]  cfg_err_code,
    output logic [6:0]  drp_addr,
    output logic        drp_en,
    output logic        drp_we,
    output logic [15:0] drp_di,
    input  logic [15:0] drp_do,
    input  logic        drp_rdy,
    output logic        mmcm_rst,
    input  logic        mmcm_locked
);

    typedef enum logic [3:0] {
        S_IDLE, S_RD1, S_WRD1, S_WR1, S_WWR1,
        S_RD2, S_WRD2, S_WR2, S_WWR2, S_RELEASE, S_WLOCK
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  sel_q, sel_d;
    logic [6:0]  div_q, div_d;
    logic [15:0] rd1_q, rd1_d, rd2_q, rd2_d;
    logic [15:0] cnt_q, cnt_d;
    logic        done_q, done_d, err_q, err_d;
    logic [1:0]  code_q, code_d;
    logic        lock_s1_q, lock_s2_q;

    logic [6:0]  reg1_addr, reg2_addr, lo_full;
    logic [5:0]  hi, lo;
    logic        edge_bit, nocount;
    logic [15:0] new1, new2;
    logic        drp_to, lock_to, wait_st;

    always_comb begin
        case (sel_q)
            3'd0:    reg1_addr = 7'h08;
            3'd1:    reg1_addr = 7'h0A;
            3'd2:    reg1_addr = 7'h0C;
            3'd3:    reg1_addr = 7'h0E;
            3'd4:    reg1_addr = 7'h10;
            3'd5:    reg1_addr = 7'h06;
            3'd6:    reg1_addr = 7'h12;
            default: reg1_addr = 7'h14;
        endcase
        reg2_addr = {reg1_addr[6:1], 1'b1};
    end

    // Divide 1 bypasses the counter: nocount set, edge cleared, hi/lo forced to 1.
    always_comb begin
        lo_full = div_q - {1'b0, div_q[6:1]};
        if (div_q == 7'd1) begin
            hi       = 6'd1;
            lo       = 6'd1;
            edge_bit = 1'b0;
            nocount  = 1'b1;
        end else begin
            hi       = div_q[6:1];
            lo       = lo_full[5:0];
            edge_bit = div_q[0];
            nocount  = 1'b0;
        end
        new1 = {rd1_q[15:12], hi, lo};
        new2 = {rd2_q[15:8], edge_bit, nocount, rd2_q[5:0]};
    end

    assign drp_to  = (cnt_q == 16'(DRP_TIMEOUT - 1));
    assign lock_to = (cnt_q == 16'(LOCK_TIMEOUT - 1));
    assign wait_st = (state_q == S_WRD1) || (state_q == S_WWR1) || (state_q == S_WRD2) ||
                     (state_q == S_WWR2) || (state_q == S_WLOCK);

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        div_d   = div_q;
        rd1_d   = rd1_q;
        rd2_d   = rd2_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        code_d  = code_q;
        case (state_q)
            S_IDLE: if (cfg_en) begin
                if (cfg_divide == 7'd0 || cfg_divide == 7'd127) begin
                    err_d  = 1'b1;
                    code_d = 2'd1;
                end else begin
                    sel_d   = cfg_sel;
                    div_d   = cfg_divide;
                    code_d  = 2'd0;
                    state_d = S_RD1;
                end
            end
            S_RD1:  state_d = S_WRD1;
            S_WRD1: if (drp_rdy) begin
                rd1_d   = drp_do;
                state_d = S_WR1;
            end else if (drp_to) begin
                err_d   = 1'b1;
                code_d  = 2'd2;
                state_d = S_IDLE;
            end
            S_WR1:  state_d = S_WWR1;
            S_WWR1: if (drp_rdy) begin
                state_d = S_RD2;
            end else if (drp_to) begin
                err_d   = 1'b1;
                code_d  = 2'd2;
                state_d = S_IDLE;
            end
            S_RD2:  state_d = S_WRD2;
            S_WRD2: if (drp_rdy) begin
                rd2_d   = drp_do;
                state_d = S_WR2;
            end else if (drp_to) begin
                err_d   = 1'b1;
                code_d  = 2'd2;
                state_d = S_IDLE;
            end
            S_WR2:  state_d = S_WWR2;
            S_WWR2: if (drp_rdy) begin
                state_d = S_RELEASE;
            end else if (drp_to) begin
                err_d   = 1'b1;
                code_d  = 2'd2;
                state_d = S_IDLE;
            end
            S_RELEASE: state_d = S_WLOCK;
            S_WLOCK: if (lock_s2_q) begin
                done_d  = 1'b1;
                code_d  = 2'd0;
                state_d = S_IDLE;
            end else if (lock_to) begin
                err_d   = 1'b1;
                code_d  = 2'd3;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        cnt_d = (wait_st && state_d == state_q) ? cnt_q + 16'd1 : 16'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            sel_q     <= '0;
            div_q     <= '0;
            rd1_q     <= '0;
            rd2_q     <= '0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            code_q    <= '0;
            lock_s1_q <= 1'b0;
            lock_s2_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            div_q     <= div_d;
            rd1_q     <= rd1_d;
            rd2_q     <= rd2_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
            err_q     <= err_d;
            code_q    <= code_d;
            lock_s1_q <= mmcm_locked;
            lock_s2_q <= lock_s1_q;
        end
    end

    always_comb begin
        drp_addr = '0;
        drp_di   = '0;
        drp_en   = 1'b0;
        drp_we   = 1'b0;
        mmcm_rst = 1'b0;
        case (state_q)
            S_RD1, S_WRD1, S_WR1, S_WWR1: drp_addr = reg1_addr;
            S_RD2, S_WRD2, S_WR2, S_WWR2: drp_addr = reg2_addr;
            default: drp_addr = '0;
        endcase
        case (state_q)
            S_WR1, S_WWR1: drp_di = new1;
            S_WR2, S_WWR2: drp_di = new2;
            default:       drp_di = '0;
        endcase
        drp_en   = (state_q == S_RD1) || (state_q == S_WR1) || (state_q == S_RD2) || (state_q == S_WR2);
        drp_we   = (state_q == S_WR1) || (state_q == S_WR2);
        mmcm_rst = (state_q != S_IDLE) && (state_q != S_RELEASE) && (state_q != S_WLOCK);
    end

    assign cfg_busy     = (state_q != S_IDLE);
    assign cfg_done     = done_q;
    assign cfg_err      = err_q;
    assign cfg_err_code = code_q;

endmodule
